// File: rtl/sd_spi_cmd_ctrl_if.sv
// rtl/sd_spi_cmd_ctrl_if.sv - host/card signal bundle for the SD SPI command sequencer
interface sd_spi_cmd_ctrl_if;
  logic        CLK_en;
  logic        START;
  logic [5:0]  CMD_INDEX;
  logic [31:0] CMD_ARG;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  R1;
  logic        TIMEOUT;
  logic        SCK;
  logic        MOSI;
  logic        MISO;
  logic        nCS;

  modport master (
    output CLK_en, START, CMD_INDEX, CMD_ARG, MISO,
    input  BUSY, DONE, R1, TIMEOUT, SCK, MOSI, nCS
  );

  modport slave (
    input  CLK_en, START, CMD_INDEX, CMD_ARG, MISO,
    output BUSY, DONE, R1, TIMEOUT, SCK, MOSI, nCS
  );
endinterface

// File: rtl/sd_spi_cmd_ctrl.sv
// rtl/sd_spi_cmd_ctrl.sv - SPI-mode SD command sequencer: power-up clocks, CRC7 command frame, R1 scan, Ncs tail
module sd_spi_cmd_ctrl #(
  parameter int SCK_DIV      = 4,
  parameter int INIT_CLOCKS  = 80,
  parameter int RESP_TIMEOUT = 8
) (
  input logic            CLK,
  input logic            nRESET,
  sd_spi_cmd_ctrl_if.slave bus
);
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BW = $clog2((INIT_CLOCKS > 48) ? INIT_CLOCKS : 48);
  localparam int WW = $clog2(RESP_TIMEOUT * 8 + 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CMD, S_RESP, S_TAIL} state_t;
  state_t state, state_nx;

  logic [DW-1:0] div;
  logic          sck;
  logic [BW-1:0] bitcnt;
  logic [WW-1:0] waitcnt;
  logic [2:0]    nb;
  logic          collecting;
  logic          fin;
  logic [47:0]   sr;
  logic [6:0]    crc;
  logic [6:0]    crc_nx;
  logic [6:0]    rsh;
  logic [7:0]    r1;
  logic          timeout;
  logic          done;
  logic          tick, rise, fall;

  assign tick   = bus.CLK_en && (state != S_IDLE) && (div == DW'(SCK_DIV - 1));
  assign rise   = tick && !sck;
  assign fall   = tick && sck;
  // x^7 + x^3 + 1, fed with the bit currently on MOSI
  assign crc_nx = {crc[5:0], 1'b0} ^ ({7{sr[47] ^ crc[6]}} & 7'h09);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= S_INIT;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT: if (fall && bitcnt == BW'(INIT_CLOCKS - 1)) state_nx = S_IDLE;
      S_IDLE: if (bus.START && bus.CLK_en) state_nx = S_CMD;
      S_CMD:  if (fall && bitcnt == BW'(47)) state_nx = S_RESP;
      S_RESP: if (fall && fin) state_nx = S_TAIL;
      S_TAIL: if (fall && bitcnt == BW'(7)) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      div        <= '0;
      sck        <= 1'b0;
      bitcnt     <= '0;
      waitcnt    <= '0;
      nb         <= '0;
      collecting <= 1'b0;
      fin        <= 1'b0;
      sr         <= '1;
      crc        <= '0;
      rsh        <= '0;
      r1         <= 8'hFF;
      timeout    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.CLK_en) begin
        if (state == S_IDLE || div == DW'(SCK_DIV - 1)) div <= '0;
        else                                            div <= div + 1'b1;
        if (tick) sck <= ~sck;
      end
      case (state)
        S_INIT: if (fall) bitcnt <= (bitcnt == BW'(INIT_CLOCKS - 1)) ? '0 : bitcnt + 1'b1;
        S_IDLE: if (bus.START && bus.CLK_en) begin
          sr         <= {2'b01, bus.CMD_INDEX, bus.CMD_ARG, 8'h01};
          crc        <= '0;
          timeout    <= 1'b0;
          bitcnt     <= '0;
          waitcnt    <= '0;
          nb         <= '0;
          collecting <= 1'b0;
          fin        <= 1'b0;
        end
        S_CMD: if (fall) begin
          if (bitcnt < BW'(40)) crc <= crc_nx;
          // after the last payload bit the computed CRC is loaded into the frame
          sr <= (bitcnt == BW'(39)) ? {crc_nx, 1'b1, sr[38:0], 1'b1} : {sr[46:0], 1'b1};
          bitcnt <= (bitcnt == BW'(47)) ? '0 : bitcnt + 1'b1;
        end
        S_RESP: if (rise && !fin) begin
          if (collecting) begin
            rsh <= {rsh[5:0], bus.MISO};
            nb  <= nb + 1'b1;
            if (nb == 3'd7) begin
              r1  <= {rsh, bus.MISO};
              fin <= 1'b1;
            end
          end else if (!bus.MISO) begin
            collecting <= 1'b1;
            rsh        <= '0;
            nb         <= 3'd1;
          end else if (waitcnt == WW'(RESP_TIMEOUT * 8 - 1)) begin
            r1      <= 8'hFF;
            timeout <= 1'b1;
            fin     <= 1'b1;
          end else begin
            waitcnt <= waitcnt + 1'b1;
          end
        end
        S_TAIL: if (fall) begin
          if (bitcnt == BW'(7)) begin
            bitcnt <= '0;
            done   <= 1'b1;
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SCK     = sck;
  assign bus.MOSI    = (state == S_CMD) ? sr[47] : 1'b1;
  assign bus.nCS     = !(state == S_CMD || state == S_RESP || state == S_TAIL);
  assign bus.BUSY    = (state != S_IDLE);
  assign bus.DONE    = done;
  assign bus.R1      = r1;
  assign bus.TIMEOUT = timeout;
endmodule

// File: tb/tb_sd_spi_cmd_ctrl.sv
// tb/tb_sd_spi_cmd_ctrl.sv - randomized self-checking bench for sd_spi_cmd_ctrl
module tb_sd_spi_cmd_ctrl;
  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  sd_spi_cmd_ctrl_if bus();

  sd_spi_cmd_ctrl #(.SCK_DIV(4), .INIT_CLOCKS(80), .RESP_TIMEOUT(8)) dut (
    .CLK(CLK), .nRESET(nRESET), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int en_mode = 0;
  int phase = 0;
  int en_cnt = 0;
  int prev_en = 0;
  bit have_prev = 0;
  int period_bad = 0;
  int init_rises = 0;
  int init_mosi_bad = 0;
  int falls = 0;
  logic mosi_log[$];
  logic miso_q[$];

  logic [47:0] obs_frame;
  int          obs_resp, obs_dn, obs_mosi_bad;
  bit          obs_wait_to, obs_second;
  logic        obs_busy_after, obs_ncs_after;
  int          exp_resp;
  logic [7:0]  exp_r1;
  logic        exp_to;
  logic [47:0] frame_cmd8;

  initial forever begin
    @(posedge CLK); #1;
    phase = (phase + 1) % 3;
    bus.CLK_en = (en_mode == 0) ? 1'b1 : (phase == 0);
  end

  initial forever begin
    @(negedge CLK);
    if (bus.CLK_en) en_cnt++;
  end

  initial forever begin
    @(posedge bus.SCK);
    if (bus.nCS) begin
      init_rises++;
      if (bus.MOSI !== 1'b1) init_mosi_bad++;
    end else begin
      mosi_log.push_back(bus.MOSI);
      if (have_prev && (en_cnt - prev_en) != 8) period_bad++;
      have_prev = 1;
    end
    prev_en = en_cnt;
  end

  // card side: shifts response bits on falling SCK once the 48-bit frame is out
  initial forever begin
    @(negedge bus.SCK);
    falls++;
    if (falls >= 48) bus.MISO = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b1;
  end

  function automatic logic [47:0] model_frame(logic [5:0] idx, logic [31:0] arg);
    logic [39:0] m;
    logic [46:0] r;
    m = {2'b01, idx, arg};
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    return {m, r[6:0], 1'b1};
  endfunction

  task automatic build_resp(input int lead, input logic [7:0] r1v, input bit use_r1);
    logic bits[$];
    int z;
    bits.delete();
    for (int i = 0; i < lead; i++) bits.push_back(1'b1);
    if (use_r1) for (int i = 7; i >= 0; i--) bits.push_back(r1v[i]);
    z = -1;
    for (int i = 0; i < bits.size(); i++) if (z < 0 && bits[i] == 1'b0) z = i;
    if (z < 0 || z >= 64) begin
      exp_resp = 64; exp_r1 = 8'hFF; exp_to = 1'b0 + 1'b1;
    end else begin
      exp_resp = z + 8; exp_to = 1'b0;
      for (int k = 0; k < 8; k++) exp_r1[7-k] = (z + k < bits.size()) ? bits[z+k] : 1'b1;
    end
    miso_q = bits;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit pulse_start);
    int n, sz;
    mosi_log.delete();
    falls = 0; have_prev = 0; period_bad = 0;
    bus.MISO = 1'b1;
    @(negedge CLK);
    bus.CMD_INDEX = idx; bus.CMD_ARG = arg; bus.START = 1'b1;
    n = 0;
    while (!bus.BUSY && n < 50) begin @(negedge CLK); n++; end
    bus.START = 1'b0;
    if (pulse_start) begin
      repeat (60) @(negedge CLK);
      bus.START = 1'b1;
      repeat (6) @(negedge CLK);
      bus.START = 1'b0;
    end
    obs_dn = 0; n = 0; obs_wait_to = 0;
    forever begin
      @(negedge CLK); n++;
      if (bus.DONE) obs_dn++;
      else if (obs_dn > 0) break;
      if (n > 10000) begin obs_wait_to = 1; break; end
    end
    obs_busy_after = bus.BUSY;
    obs_ncs_after = bus.nCS;
    obs_frame = '1;
    for (int i = 0; i < 48 && i < mosi_log.size(); i++) obs_frame[47-i] = mosi_log[i];
    obs_resp = mosi_log.size() - 56;
    obs_mosi_bad = 0;
    for (int i = 48; i < mosi_log.size(); i++) if (mosi_log[i] !== 1'b1) obs_mosi_bad++;
    sz = mosi_log.size();
    obs_second = 0;
    repeat (100) begin
      @(negedge CLK);
      if (bus.BUSY) obs_second = 1;
    end
    if (mosi_log.size() != sz) obs_second = 1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    total++; if ({bus.SCK, bus.MOSI, bus.nCS, bus.BUSY, bus.DONE} !== 5'b01110) begin bad++; $display("FAIL reset_ctrl got=%b exp=01110", {bus.SCK, bus.MOSI, bus.nCS, bus.BUSY, bus.DONE}); end
    total++; if ({bus.R1, bus.TIMEOUT} !== {8'hFF, 1'b0}) begin bad++; $display("FAIL reset_r1 got=%h/%b exp=ff/0", bus.R1, bus.TIMEOUT); end
  endtask

  task automatic test_init;
    int n;
    init_rises = 0; init_mosi_bad = 0; mosi_log.delete();
    @(negedge CLK); nRESET = 1'b1;
    n = 0;
    while (n < 2000) begin @(negedge CLK); n++; if (!bus.BUSY) break; end
    total++; if (n < 639 || n > 641) begin bad++; $display("FAIL init_len got=%0d exp=640", n); end
    total++; if (init_rises !== 80) begin bad++; $display("FAIL init_clocks got=%0d exp=80", init_rises); end
    total++; if (init_mosi_bad !== 0 || mosi_log.size() !== 0) begin bad++; $display("FAIL init_lines got=%0d/%0d exp=0/0", init_mosi_bad, mosi_log.size()); end
  endtask

  task automatic test_cmd0;
    build_resp(16, 8'h01, 1);
    run_cmd(6'd0, 32'h0, 0);
    total++; if (obs_wait_to) begin bad++; $display("FAIL cmd0_done_wait got=timeout exp=done"); end
    total++; if (obs_frame !== 48'h400000000095) begin bad++; $display("FAIL cmd0_frame got=%h exp=400000000095", obs_frame); end
    total++; if (bus.R1 !== 8'h01 || bus.TIMEOUT !== 1'b0) begin bad++; $display("FAIL cmd0_r1 got=%h/%b exp=01/0", bus.R1, bus.TIMEOUT); end
    total++; if (obs_dn !== 1) begin bad++; $display("FAIL cmd0_done_width got=%0d exp=1", obs_dn); end
    total++; if (obs_resp !== exp_resp || obs_mosi_bad !== 0) begin bad++; $display("FAIL cmd0_resp_tail got=%0d/%0d exp=%0d/0", obs_resp, obs_mosi_bad, exp_resp); end
    total++; if (obs_ncs_after !== 1'b1 || obs_busy_after !== 1'b0) begin bad++; $display("FAIL cmd0_idle got=%b%b exp=10", obs_ncs_after, obs_busy_after); end
  endtask

  task automatic test_cmd8;
    build_resp(3, 8'h01, 1);
    run_cmd(6'd8, 32'h000001AA, 0);
    frame_cmd8 = obs_frame;
    total++; if (obs_frame !== 48'h48000001AA87) begin bad++; $display("FAIL cmd8_frame got=%h exp=48000001aa87", obs_frame); end
    total++; if (bus.R1 !== 8'h01 || bus.TIMEOUT !== 1'b0) begin bad++; $display("FAIL cmd8_r1 got=%h/%b exp=01/0", bus.R1, bus.TIMEOUT); end
    total++; if (obs_resp !== exp_resp) begin bad++; $display("FAIL cmd8_resp_len got=%0d exp=%0d", obs_resp, exp_resp); end
  endtask

  task automatic test_timeout;
    build_resp(100, 8'h00, 0);
    run_cmd(6'd17, 32'h12345678, 0);
    total++; if (obs_resp !== 64) begin bad++; $display("FAIL timeout_len got=%0d exp=64", obs_resp); end
    total++; if (bus.R1 !== 8'hFF || bus.TIMEOUT !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%h/%b exp=ff/1", bus.R1, bus.TIMEOUT); end
    total++; if (obs_dn !== 1 || obs_mosi_bad !== 0) begin bad++; $display("FAIL timeout_done got=%0d/%0d exp=1/0", obs_dn, obs_mosi_bad); end
  endtask

  task automatic test_boundary;
    build_resp(63, 8'h05, 1);
    run_cmd(6'd55, 32'h0, 0);
    total++; if (bus.R1 !== 8'h05 || bus.TIMEOUT !== 1'b0 || obs_resp !== 71) begin bad++; $display("FAIL bound_last got=%h/%b/%0d exp=05/0/71", bus.R1, bus.TIMEOUT, obs_resp); end
    build_resp(64, 8'h05, 1);
    run_cmd(6'd55, 32'h0, 0);
    total++; if (bus.R1 !== 8'hFF || bus.TIMEOUT !== 1'b1 || obs_resp !== 64) begin bad++; $display("FAIL bound_over got=%h/%b/%0d exp=ff/1/64", bus.R1, bus.TIMEOUT, obs_resp); end
  endtask

  task automatic test_toggle;
    en_mode = 1;
    build_resp(3, 8'h01, 1);
    run_cmd(6'd8, 32'h000001AA, 1);
    en_mode = 0;
    total++; if (obs_frame !== frame_cmd8) begin bad++; $display("FAIL toggle_frame got=%h exp=%h", obs_frame, frame_cmd8); end
    total++; if (period_bad !== 0) begin bad++; $display("FAIL toggle_period got=%0d bad periods exp=0", period_bad); end
    total++; if (obs_second !== 1'b0 || obs_dn !== 1) begin bad++; $display("FAIL toggle_single got=%b/%0d exp=0/1", obs_second, obs_dn); end
    total++; if (bus.R1 !== 8'h01) begin bad++; $display("FAIL toggle_r1 got=%h exp=01", bus.R1); end
  endtask

  task automatic test_random;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1v;
    logic [47:0] ef;
    for (int it = 0; it < 5; it++) begin
      idx = 6'($urandom); arg = $urandom; r1v = 8'($urandom);
      build_resp(int'($urandom_range(0, 70)), r1v, 1);
      run_cmd(idx, arg, 0);
      ef = model_frame(idx, arg);
      total++; if (obs_frame !== ef) begin bad++; $display("FAIL rand_frame it=%0d got=%h exp=%h", it, obs_frame, ef); end
      total++; if (bus.R1 !== exp_r1 || bus.TIMEOUT !== exp_to || obs_resp !== exp_resp) begin bad++; $display("FAIL rand_resp it=%0d got=%h/%b/%0d exp=%h/%b/%0d", it, bus.R1, bus.TIMEOUT, obs_resp, exp_r1, exp_to, exp_resp); end
    end
  endtask

  task automatic test_reset_mid;
    miso_q.delete(); bus.MISO = 1'b1;
    @(negedge CLK);
    bus.CMD_INDEX = 6'd0; bus.CMD_ARG = 32'h0; bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    repeat (150) @(negedge CLK);
    #2 nRESET = 1'b0;
    #1;
    total++; if ({bus.SCK, bus.MOSI, bus.nCS, bus.BUSY, bus.DONE} !== 5'b01110) begin bad++; $display("FAIL midrst_ctrl got=%b exp=01110", {bus.SCK, bus.MOSI, bus.nCS, bus.BUSY, bus.DONE}); end
    total++; if ({bus.R1, bus.TIMEOUT} !== {8'hFF, 1'b0}) begin bad++; $display("FAIL midrst_r1 got=%h/%b exp=ff/0", bus.R1, bus.TIMEOUT); end
    test_init();
    build_resp(8, 8'h01, 1);
    run_cmd(6'd0, 32'h0, 0);
    total++; if (obs_frame !== 48'h400000000095 || bus.R1 !== 8'h01 || obs_dn !== 1) begin bad++; $display("FAIL midrst_cmd0 got=%h/%h/%0d exp=400000000095/01/1", obs_frame, bus.R1, obs_dn); end
  endtask

  initial begin
    bus.CLK_en = 1'b1; bus.START = 1'b0; bus.CMD_INDEX = '0; bus.CMD_ARG = '0; bus.MISO = 1'b1;
    test_reset();
    test_init();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_boundary();
    test_toggle();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
